// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - shared encodings for the multicycle ALU sequencer
//
// Purpose: state encoding, opcode constants and datapath mux select encodings
//          shared by alu_seq_ctrl and alu_seq_decode.
// Ports:   none (package).
package alu_seq_ctrl_pkg;

  typedef enum logic [3:0] {
    st_reset     = 4'd0,
    st_fetch     = 4'd1,
    st_decode    = 4'd2,
    st_exec_r    = 4'd3,
    st_r_wb      = 4'd4,
    st_mem_addr  = 4'd5,
    st_mem_rd    = 4'd6,
    st_lw_wb     = 4'd7,
    st_mem_wr    = 4'd8,
    st_branch    = 4'd9,
    st_jump      = 4'd10,
    st_addi_exec = 4'd11,
    st_addi_wb   = 4'd12,
    st_exc       = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] op_rtype = 6'h00;
  localparam logic [5:0] op_lw    = 6'h23;
  localparam logic [5:0] op_sw    = 6'h2b;
  localparam logic [5:0] op_beq   = 6'h04;
  localparam logic [5:0] op_j     = 6'h02;
  localparam logic [5:0] op_addi  = 6'h08;

  // ALU operand A select
  localparam logic srca_pc   = 1'b0;
  localparam logic srca_rega = 1'b1;

  // ALU operand B select
  localparam logic [1:0] srcb_regb   = 2'b00;
  localparam logic [1:0] srcb_four   = 2'b01;
  localparam logic [1:0] srcb_imm    = 2'b10;
  localparam logic [1:0] srcb_imm_sh = 2'b11;

  // ALU operation
  localparam logic [1:0] aluop_add   = 2'b00;
  localparam logic [1:0] aluop_sub   = 2'b01;
  localparam logic [1:0] aluop_funct = 2'b10;

  // PC source select
  localparam logic [1:0] pcsrc_alu    = 2'b00;
  localparam logic [1:0] pcsrc_aluout = 2'b01;
  localparam logic [1:0] pcsrc_jump   = 2'b10;
  localparam logic [1:0] pcsrc_exc    = 2'b11;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - opcode to dispatch-state decoder
//
// Purpose: combinational mapping of the instruction opcode to the state the
//          sequencer enters after DECODE, and after MEM_ADDR.
// Ports:   opcode   in  6  IR[31:26]
//          dispatch out 4  successor of DECODE
//          mem_next out 4  successor of MEM_ADDR
module alu_seq_decode
  import alu_seq_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output state_t     dispatch,
  output state_t     mem_next
);

  always_comb begin
    dispatch = st_exc;
    case (opcode)
      op_rtype:     dispatch = st_exec_r;
      op_lw, op_sw: dispatch = st_mem_addr;
      op_beq:       dispatch = st_branch;
      op_j:         dispatch = st_jump;
      op_addi:      dispatch = st_addi_exec;
      default:      dispatch = st_exc;
    endcase
  end

  // Only reachable with a load/store opcode; anything else traps.
  always_comb begin
    mem_next = st_exc;
    case (opcode)
      op_lw:   mem_next = st_mem_rd;
      op_sw:   mem_next = st_mem_wr;
      default: mem_next = st_exc;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multicycle ALU/memory sequencer control FSM
//
// Purpose: 14-state control FSM for a multicycle datapath. State register is
//          asynchronously reset; outputs are decoded from the registered state
//          (plus mem_ready in FETCH and zero in BRANCH).
// Ports:   clk, reset (async, active-high)
//          opcode[5:0], zero, overflow, mem_ready           inputs
//          alu_src_a, alu_src_b[1:0], alu_op[1:0]           ALU selects
//          pc_write, pc_write_cond, ir_write, mem_read, mem_write,
//          reg_write, reg_dst, mem_to_reg, epc_write         strobes/selects
//          pc_source[1:0], state_out[3:0]                    PC mux, debug
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       epc_write,
  output logic [1:0] pc_source,
  output logic [3:0] state_out
);

  state_t state;
  state_t dispatch;
  state_t mem_next;

  alu_seq_decode u_decode (
    .opcode   (opcode),
    .dispatch (dispatch),
    .mem_next (mem_next)
  );

  // opcode is only consulted through dispatch/mem_next in DECODE and MEM_ADDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= st_reset;
    end else begin
      case (state)
        st_reset:     state <= st_fetch;
        st_fetch:     state <= mem_ready ? st_decode : st_fetch;
        st_decode:    state <= dispatch;
        st_exec_r:    state <= overflow ? st_exc : st_r_wb;
        st_r_wb:      state <= st_fetch;
        st_mem_addr:  state <= mem_next;
        st_mem_rd:    state <= mem_ready ? st_lw_wb : st_mem_rd;
        st_lw_wb:     state <= st_fetch;
        st_mem_wr:    state <= mem_ready ? st_fetch : st_mem_wr;
        st_branch:    state <= st_fetch;
        st_jump:      state <= st_fetch;
        st_addi_exec: state <= overflow ? st_exc : st_addi_wb;
        st_addi_wb:   state <= st_fetch;
        st_exc:       state <= st_fetch;
        default:      state <= st_reset;
      endcase
    end
  end

  always_comb begin
    alu_src_a     = srca_pc;
    alu_src_b     = srcb_regb;
    alu_op        = aluop_add;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    epc_write     = 1'b0;
    pc_source     = pcsrc_alu;
    case (state)
      st_fetch: begin
        mem_read  = 1'b1;
        alu_src_a = srca_pc;
        alu_src_b = srcb_four;
        alu_op    = aluop_add;
        pc_source = pcsrc_alu;
        // IR and PC+4 commit only on the cycle the fetch completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      st_decode: begin
        alu_src_a = srca_pc;
        alu_src_b = srcb_imm_sh;
        alu_op    = aluop_add;
      end
      st_exec_r: begin
        alu_src_a = srca_rega;
        alu_src_b = srcb_regb;
        alu_op    = aluop_funct;
      end
      st_r_wb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      st_mem_addr, st_addi_exec: begin
        alu_src_a = srca_rega;
        alu_src_b = srcb_imm;
        alu_op    = aluop_add;
      end
      st_mem_rd: mem_read = 1'b1;
      st_lw_wb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      st_mem_wr: mem_write = 1'b1;
      st_branch: begin
        alu_src_a     = srca_rega;
        alu_src_b     = srcb_regb;
        alu_op        = aluop_sub;
        pc_write_cond = 1'b1;
        pc_source     = pcsrc_aluout;
        pc_write      = zero;
      end
      st_jump: begin
        pc_write  = 1'b1;
        pc_source = pcsrc_jump;
      end
      st_addi_wb: reg_write = 1'b1;
      st_exc: begin
        epc_write = 1'b1;
        pc_write  = 1'b1;
        pc_source = pcsrc_exc;
      end
      default: ;
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard testbench for alu_seq_ctrl
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero, overflow, mem_ready;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, epc_write;
  logic [3:0] state_out;

  alu_seq_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .epc_write(epc_write),
    .pc_source(pc_source), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       a;
    logic [1:0] b;
    logic [1:0] op;
    logic       pcw, pcwc, irw, mrd, mwr, rw, rd, m2r, epc;
    logic [1:0] pcs;
  } ctl_t;

  ctl_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Control word the datapath must see in a given step of an instruction.
  function automatic ctl_t model(state_t st, logic mr, logic z);
    ctl_t c;
    c = '0;
    c.st = st;
    case (st)
      st_fetch:     begin c.mrd = 1; c.b = 2'b01; c.irw = mr; c.pcw = mr; end
      st_decode:    c.b = 2'b11;
      st_exec_r:    begin c.a = 1; c.op = 2'b10; end
      st_r_wb:      begin c.rd = 1; c.rw = 1; end
      st_mem_addr:  begin c.a = 1; c.b = 2'b10; end
      st_mem_rd:    c.mrd = 1;
      st_lw_wb:     begin c.m2r = 1; c.rw = 1; end
      st_mem_wr:    c.mwr = 1;
      st_branch:    begin c.a = 1; c.op = 2'b01; c.pcwc = 1; c.pcs = 2'b01; c.pcw = z; end
      st_jump:      begin c.pcw = 1; c.pcs = 2'b10; end
      st_addi_exec: begin c.a = 1; c.b = 2'b10; end
      st_addi_wb:   c.rw = 1;
      st_exc:       begin c.epc = 1; c.pcw = 1; c.pcs = 2'b11; end
      default:      ;
    endcase
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, queue what the DUT must show this cycle.
  task automatic step(state_t st, logic mr, logic z, logic ov, logic [5:0] opc);
    mem_ready = mr;
    zero      = z;
    overflow  = ov;
    opcode    = opc;
    expq.push_back(model(st, mr, z));
    @(posedge clk);
    #1;
  endtask

  // Expands one instruction into its expected step sequence; opcode is
  // scrambled in every step where it must be ignored.
  task automatic run_instr(logic [5:0] opc, logic ov, logic z, int fw, int mw);
    for (int i = 0; i < fw; i++) step(st_fetch, 1'b0, rb(), rb(), rop());
    step(st_fetch, 1'b1, rb(), rb(), rop());
    step(st_decode, rb(), rb(), rb(), opc);
    case (opc)
      op_rtype: begin
        step(st_exec_r, rb(), rb(), ov, rop());
        step(ov ? st_exc : st_r_wb, rb(), rb(), rb(), rop());
      end
      op_lw: begin
        step(st_mem_addr, rb(), rb(), rb(), opc);
        for (int i = 0; i < mw; i++) step(st_mem_rd, 1'b0, rb(), rb(), rop());
        step(st_mem_rd, 1'b1, rb(), rb(), rop());
        step(st_lw_wb, rb(), rb(), rb(), rop());
      end
      op_sw: begin
        step(st_mem_addr, rb(), rb(), rb(), opc);
        for (int i = 0; i < mw; i++) step(st_mem_wr, 1'b0, rb(), rb(), rop());
        step(st_mem_wr, 1'b1, rb(), rb(), rop());
      end
      op_beq:  step(st_branch, rb(), z, rb(), rop());
      op_j:    step(st_jump, rb(), rb(), rb(), rop());
      op_addi: begin
        step(st_addi_exec, rb(), rb(), ov, rop());
        step(ov ? st_exc : st_addi_wb, rb(), rb(), rb(), rop());
      end
      default: step(st_exc, rb(), rb(), rb(), rop());
    endcase
  endtask

  // Monitor: compares every cycle for which stimulus queued an expectation.
  always @(negedge clk) begin
    ctl_t act, e;
    act = {state_out, alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond,
           ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
           epc_write, pc_source};
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL ctl_word: state got %0d expected %0d, word got %h expected %h at %0t",
                 act.st, e.st, act, e, $time);
      end
    end
    n_checks++;
    if (reg_write === 1'b1 && mem_write === 1'b1) begin
      n_fail++;
      $display("FAIL rw_mw_exclusive: got reg_write=1 mem_write=1 expected not both at %0t", $time);
    end
  end

  initial begin
    logic [5:0] legal [6];
    legal[0] = op_rtype; legal[1] = op_lw; legal[2] = op_sw;
    legal[3] = op_beq;   legal[4] = op_j;  legal[5] = op_addi;

    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; overflow = 1'b0; opcode = '0;
    @(posedge clk);
    #1;
    step(st_reset, 1'b1, rb(), rb(), rop());
    step(st_reset, 1'b1, rb(), rb(), rop());
    reset = 1'b0;
    step(st_reset, rb(), rb(), rb(), rop());

    // Directed scenarios
    run_instr(op_rtype, 1'b0, 1'b0, 0, 0);
    run_instr(op_lw,    1'b0, 1'b0, 1, 3);
    run_instr(op_beq,   1'b0, 1'b1, 0, 0);
    run_instr(op_beq,   1'b0, 1'b0, 0, 0);
    run_instr(op_addi,  1'b1, 1'b0, 0, 0);
    run_instr(op_rtype, 1'b1, 1'b0, 0, 0);
    run_instr(6'h3f,    1'b0, 1'b0, 0, 0);
    run_instr(op_sw,    1'b0, 1'b0, 2, 1);
    run_instr(op_j,     1'b0, 1'b0, 0, 0);

    // Reset asserted mid-MEM_WR must take effect before any clock edge
    step(st_fetch, 1'b1, rb(), rb(), rop());
    step(st_decode, rb(), rb(), rb(), op_sw);
    step(st_mem_addr, rb(), rb(), rb(), op_sw);
    step(st_mem_wr, 1'b0, rb(), rb(), rop());
    mem_ready = 1'b0;
    #1;
    check("pre_reset_state", 32'(state_out), 32'(st_mem_wr));
    check("pre_reset_mem_write", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_state", 32'(state_out), 32'(st_reset));
    check("async_reset_mem_write", 32'(mem_write), 32'd0);
    check("async_reset_outputs",
          32'({alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, ir_write,
               mem_read, mem_write, reg_write, reg_dst, mem_to_reg, epc_write, pc_source}),
          32'd0);
    @(posedge clk);
    #1;
    step(st_reset, 1'b1, rb(), rb(), rop());
    reset = 1'b0;
    step(st_reset, rb(), rb(), rb(), rop());

    // Randomized instruction stream
    for (int n = 0; n < 120; n++) begin
      logic [5:0] opc;
      if ($urandom_range(0, 7) == 0) opc = rop();
      else opc = legal[$urandom_range(0, 5)];
      run_instr(opc, rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; one clock, no other clock or reset.
REQ-003 SHALL have inputs: opcode in 6 (IR[31:26]); zero in 1 (ALU zero flag); overflow in 1 (ALU overflow flag); mem_ready in 1 (memory access complete this cycle).
REQ-004 SHALL have outputs: alu_src_a out 1 (0 = PC, 1 = regA); alu_src_b out 2 (00 = regB, 01 = const 4, 10 = sign-ext imm, 11 = shifted imm); alu_op out 2 (00 add, 01 sub, 10 funct-decoded).
REQ-005 SHALL have outputs, 1 bit each: pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, epc_write; plus pc_source out 2 (00 ALU, 01 ALUOut, 10 jump target, 11 exception vector) and state_out out 4 (current state, debug).

Function
REQ-006 SHALL implement a 14-state FSM: RESET, FETCH, DECODE, EXEC_R, R_WB, MEM_ADDR, MEM_RD, LW_WB, MEM_WR, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, EXC.
REQ-007 SHALL decode outputs combinationally from the registered state; only pc_write/ir_write in FETCH and pc_write in BRANCH depend on inputs; every output not listed for a state SHALL be 0.
REQ-008 RESET: all outputs 0; next state FETCH unconditionally.
REQ-009 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-010 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 0x00 EXEC_R, 0x23/0x2B MEM_ADDR, 0x04 BRANCH, 0x02 JUMP, 0x08 ADDI_EXEC, any other EXC.
REQ-011 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next EXC if overflow=1, else R_WB.
REQ-012 R_WB: reg_dst=1, mem_to_reg=0, reg_write=1; next FETCH.
REQ-013 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_RD for opcode 0x23, MEM_WR for 0x2B.
REQ-014 MEM_RD: mem_read=1; hold while mem_ready=0; then LW_WB. LW_WB: reg_dst=0, mem_to_reg=1, reg_write=1; next FETCH.
REQ-015 MEM_WR: mem_write=1; hold while mem_ready=0; then FETCH.
REQ-016 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; pc_write=zero; next FETCH.
REQ-017 JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-018 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; next EXC if overflow=1, else ADDI_WB. ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1; next FETCH.
REQ-019 EXC: epc_write=1, pc_write=1, pc_source=11, reg_write=0; next FETCH.
REQ-020 opcode SHALL be sampled in DECODE and MEM_ADDR only; opcode changes in other states SHALL have no effect.
REQ-021 mem_ready asserted in any state other than FETCH, MEM_RD or MEM_WR SHALL be ignored.
REQ-022 reg_write and mem_write SHALL never be 1 in the same cycle; an overflowing instruction SHALL never assert reg_write.

Reset
REQ-023 reset=1 SHALL force state RESET immediately, asynchronously and regardless of the clock, including mid-wait in MEM_RD/MEM_WR; all outputs go to 0 in the same cycle.
REQ-024 The first rising clk edge after reset deasserts SHALL move the FSM from RESET to FETCH.

Structure
REQ-025 State encodings (4-bit), opcode constants, and alu_src_b/pc_source/alu_op encodings SHALL live in a shared package and be used by the datapath muxes.
REQ-026 Opcode-to-dispatch-state decoding SHALL be a combinational sub-module, alu_seq_decode; the FSM register and output decode stay in alu_seq_ctrl.

Verification
REQ-027 Reset then add (opcode 0x00), mem_ready=1, overflow=0 -> states RESET, FETCH, DECODE, EXEC_R, R_WB, FETCH; alu_src_b sequence 01, 11, 00; reg_write=1 only in R_WB.
REQ-028 lw (0x23) with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1; LW_WB asserts mem_to_reg=1 and reg_write=1.
REQ-029 beq (0x04): zero=1 -> pc_write=1, pc_source=01 in BRANCH; repeat with zero=0 -> pc_write=0; both runs return to FETCH.
REQ-030 addi (0x08) with overflow=1 in ADDI_EXEC -> EXC with epc_write=1, pc_source=11; reg_write never asserted.
REQ-031 Illegal opcode 0x3F -> DECODE goes to EXC; reset pulsed mid-MEM_WR -> state_out shows RESET without waiting for a clock edge, and mem_write drops to 0.
